// File: rtl/fetch_pc_ctrl_pkg.sv
// fetch_pkg: shared encodings for the fetch PC-source controller.
//   - pc_place codes (PC source select for the fetch stage)
//   - pc_select codes (PC increment amount)
//   - controller state enum
//   - grant one-hot bit positions from the RUN-state priority encoder
//   - helper mapping an exception code to its vector slot
package fetch_pkg;

  localparam logic [3:0] PLACE_SEQ  = 4'b0000;
  localparam logic [3:0] PLACE_ZERO = 4'b0001;
  localparam logic [3:0] PLACE_V2   = 4'b0010;
  localparam logic [3:0] PLACE_V4   = 4'b0011;
  localparam logic [3:0] PLACE_V6   = 4'b0100;
  localparam logic [3:0] PLACE_IVT  = 4'b0101;
  localparam logic [3:0] PLACE_RET  = 4'b0110;
  localparam logic [3:0] PLACE_CALL = 4'b0111;
  localparam logic [3:0] PLACE_LOAD = 4'b1000;

  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_INC1 = 2'b01;
  localparam logic [1:0] SEL_INC2 = 2'b10;

  typedef enum logic [2:0] {
    ST_BOOT_PTR  = 3'd0,
    ST_BOOT_LOAD = 3'd1,
    ST_RUN       = 3'd2,
    ST_VEC_PTR   = 3'd3,
    ST_VEC_LOAD  = 3'd4
  } state_e;

  localparam int unsigned GNT_W   = 6;
  localparam int unsigned G_EXC   = 0;
  localparam int unsigned G_RET   = 1;
  localparam int unsigned G_CALL  = 2;
  localparam int unsigned G_STALL = 3;
  localparam int unsigned G_INT   = 4;
  localparam int unsigned G_SEQ   = 5;

  // Codes 2 and 3 share the addr-6 vector.
  function automatic logic [3:0] exc_place(input logic [1:0] code);
    case (code)
      2'd0:    return PLACE_V2;
      2'd1:    return PLACE_V4;
      default: return PLACE_V6;
    endcase
  endfunction

endpackage

// File: rtl/fetch_pc_ctrl_if.sv
// fetch_pc_ctrl_if: request/handshake bundle between the hazard/decode/CU
// request sources, the fetch stage and the PC-source controller.
//   Requests  : stall, is_32bit, ret_taken, call_taken, exc_req, exc_code,
//               int_req, int_en, int_index
//   Responses : exc_ack, int_ack, pc_place, pc_select, index, busy
//   master    : controller side (consumes requests, drives responses)
//   slave     : requester/fetch side (drives requests, consumes responses)
interface fetch_pc_ctrl_if #(
  parameter int unsigned IDX_W = 3
) ();

  logic             stall;
  logic             is_32bit;
  logic             ret_taken;
  logic             call_taken;
  logic             exc_req;
  logic [1:0]       exc_code;
  logic             exc_ack;
  logic             int_req;
  logic             int_en;
  logic [IDX_W-1:0] int_index;
  logic             int_ack;
  logic [3:0]       pc_place;
  logic [1:0]       pc_select;
  logic [IDX_W-1:0] index;
  logic             busy;

  modport master (
    input  stall, is_32bit, ret_taken, call_taken,
    input  exc_req, exc_code, int_req, int_en, int_index,
    output exc_ack, int_ack, pc_place, pc_select, index, busy
  );

  modport slave (
    output stall, is_32bit, ret_taken, call_taken,
    output exc_req, exc_code, int_req, int_en, int_index,
    input  exc_ack, int_ack, pc_place, pc_select, index, busy
  );

endinterface

// File: rtl/fetch_pc_ctrl_prio.sv
// fetch_pc_prio: combinational RUN-state priority encoder.
//   Inputs : exc_req_i/exc_code_i, ret_i, call_i, stall_i,
//            int_ok_i (pending interrupt and enabled), is_32bit_i
//   Outputs: place_o (pc_place code), select_o (pc_select code),
//            grant_o (one-hot winner, bit positions G_* in fetch_pkg)
// Priority, highest first: exception, return, call, stall, interrupt, sequential.
module fetch_pc_prio
  import fetch_pkg::*;
(
  input  logic             exc_req_i,
  input  logic [1:0]       exc_code_i,
  input  logic             ret_i,
  input  logic             call_i,
  input  logic             stall_i,
  input  logic             int_ok_i,
  input  logic             is_32bit_i,
  output logic [3:0]       place_o,
  output logic [1:0]       select_o,
  output logic [GNT_W-1:0] grant_o
);

  always_comb begin
    place_o  = PLACE_SEQ;
    select_o = SEL_HOLD;
    grant_o  = '0;
    if (exc_req_i) begin
      place_o        = exc_place(exc_code_i);
      grant_o[G_EXC] = 1'b1;
    end else if (ret_i) begin
      place_o        = PLACE_RET;
      grant_o[G_RET] = 1'b1;
    end else if (call_i) begin
      place_o         = PLACE_CALL;
      grant_o[G_CALL] = 1'b1;
    end else if (stall_i) begin
      place_o          = PLACE_SEQ;
      grant_o[G_STALL] = 1'b1;
    end else if (int_ok_i) begin
      place_o        = PLACE_IVT;
      grant_o[G_INT] = 1'b1;
    end else begin
      place_o        = PLACE_SEQ;
      select_o       = is_32bit_i ? SEL_INC2 : SEL_INC1;
      grant_o[G_SEQ] = 1'b1;
    end
  end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl: sequencer driving the fetch stage PC-source controls.
//   clk      : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : fetch_pc_ctrl_if.master (requests in; pc_place, pc_select,
//              index, exc_ack, int_ack, busy out)
// Boot: BOOT_PTR (PC <- 0) then, if BOOT_INDIRECT, BOOT_LOAD (PC <- mem[0]).
// Exceptions vector via VEC_LOAD; interrupts via VEC_PTR then VEC_LOAD.
module fetch_pc_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned IDX_W         = 3,
  parameter bit          BOOT_INDIRECT = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  fetch_pc_ctrl_if.master bus
);

  state_e           state_q, state_d;
  logic             int_pend_q, int_pend_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [3:0]       run_place;
  logic [1:0]       run_select;
  logic [GNT_W-1:0] run_grant;
  logic             in_run;
  logic             exc_ack;
  logic             int_ack;

  fetch_pc_prio u_prio (
    .exc_req_i  (bus.exc_req),
    .exc_code_i (bus.exc_code),
    .ret_i      (bus.ret_taken),
    .call_i     (bus.call_taken),
    .stall_i    (bus.stall),
    .int_ok_i   (int_pend_q & bus.int_en),
    .is_32bit_i (bus.is_32bit),
    .place_o    (run_place),
    .select_o   (run_select),
    .grant_o    (run_grant)
  );

  // Grants only matter in RUN; everywhere else requests are ignored.
  assign in_run  = (state_q == ST_RUN);
  assign exc_ack = in_run & run_grant[G_EXC];
  assign int_ack = in_run & run_grant[G_INT];

  // State and pending-interrupt registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_BOOT_PTR;
      int_pend_q <= 1'b0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      int_pend_q <= int_pend_d;
      idx_q      <= idx_d;
    end
  end

  // Clearing on ack wins over a simultaneous new request.
  always_comb begin
    int_pend_d = int_ack ? 1'b0 : (int_pend_q | (bus.int_req & bus.int_en));
    idx_d      = int_ack ? bus.int_index : idx_q;
  end

  // Next-state logic.
  always_comb begin
    state_d = ST_BOOT_PTR;
    case (state_q)
      ST_BOOT_PTR:  state_d = BOOT_INDIRECT ? ST_BOOT_LOAD : ST_RUN;
      ST_BOOT_LOAD: state_d = ST_RUN;
      ST_RUN: begin
        if (exc_ack)      state_d = ST_VEC_LOAD;
        else if (int_ack) state_d = ST_VEC_PTR;
        else              state_d = ST_RUN;
      end
      ST_VEC_PTR:   state_d = ST_VEC_LOAD;
      ST_VEC_LOAD:  state_d = ST_RUN;
      default:      state_d = ST_BOOT_PTR;
    endcase
  end

  // Output logic.
  always_comb begin
    bus.pc_place  = PLACE_ZERO;
    bus.pc_select = SEL_HOLD;
    bus.index     = '0;
    bus.busy      = 1'b1;
    bus.exc_ack   = exc_ack;
    bus.int_ack   = int_ack;
    case (state_q)
      ST_BOOT_PTR:  bus.pc_place = PLACE_ZERO;
      ST_BOOT_LOAD: bus.pc_place = PLACE_LOAD;
      ST_RUN: begin
        bus.busy      = 1'b0;
        bus.pc_place  = run_place;
        bus.pc_select = run_select;
        if (int_ack) bus.index = bus.int_index;
      end
      ST_VEC_PTR: begin
        bus.pc_place = PLACE_IVT;
        bus.index    = idx_q;
      end
      ST_VEC_LOAD:  bus.pc_place = PLACE_LOAD;
      default:      bus.pc_place = PLACE_ZERO;
    endcase
  end

endmodule
